// File: rtl/gost28147_pkg.sv
// Shared definitions for the gost28147 gamma-mode front-end.
//   C1 / C2      : counter step constants for N4 / N3
//   state_t      : front-end sequencing states
//   add_mod32m1  : 32-bit add with end-around carry (modulo 2^32-1, 0xFFFFFFFF kept)
package gost28147_pkg;

    localparam logic [31:0] C1 = 32'h01010104;
    localparam logic [31:0] C2 = 32'h01010101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        SWAIT = 3'd2,
        READY = 3'd3,
        GEN   = 3'd4,
        GWAIT = 3'd5,
        OUT   = 3'd6
    } state_t;

    // The carry-out is folded back into bit 0. The second add cannot carry
    // again because the low word is at most 0xFFFFFFFE whenever a carry exists.
    // A carry-free 0xFFFFFFFF result is left as is (never folded to zero).
    function automatic logic [31:0] add_mod32m1(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[31:0] + {31'b0, sum[32]};
    endfunction

endpackage

// File: rtl/gost28147_gamma_ctr.sv
// N3/N4 counter pair for gamma generation.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          take load_data as {N4,N3}
//   load_data     64-bit block from the core (encrypted synchro-package)
//   step          advance N3 by C2 (mod 2^32) and N4 by C1 (mod 2^32-1)
//   ctr_next      stepped value {N4+C1, N3+C2}, combinational from the current state
module gost28147_gamma_ctr
    import gost28147_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        step,
    output logic [63:0] ctr_next
);

    logic [31:0] n3_q, n3_d;
    logic [31:0] n4_q, n4_d;
    logic [31:0] n3_step;
    logic [31:0] n4_step;

    always_comb begin
        n3_step = n3_q + C2;
        n4_step = add_mod32m1(n4_q, C1);
        n3_d    = n3_q;
        n4_d    = n4_q;
        if (load) begin
            n3_d = load_data[31:0];
            n4_d = load_data[63:32];
        end else if (step) begin
            n3_d = n3_step;
            n4_d = n4_step;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n3_q <= 32'h0;
            n4_q <= 32'h0;
        end else begin
            n3_q <= n3_d;
            n4_q <= n4_d;
        end
    end

    assign ctr_next = {n4_step, n3_step};

endmodule

// File: rtl/gost28147_gamma.sv
// Gamma (counter) mode front-end for the gost28147 core. Encrypts the
// synchro-package S through the core to seed {N4,N3}, then for every user
// block steps the counter, encrypts it and XORs the result with the block.
// Encrypt and decrypt are the same operation.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   iv, iv_load, iv_ready            synchro-package load (taken in IDLE/READY)
//   din, din_valid, din_ready        input block handshake
//   dout, dout_valid, dout_ready     output block handshake, dout held until taken
//   core_pdata/pvalid/pready         request to core ({N4,N3} or S)
//   core_cdata/cvalid/cready         response from core
//   core_mode                        tied 0, the core always encrypts
// Optional build macro GOST28147_GAMMA_PARTIAL_EN adds din_last/din_nbytes:
// on a last block the bytes at and above din_nbytes are zeroed (0 means all 8)
// and the block returns to IDLE after its output is taken.
//
// state | meaning
// IDLE  | no synchro-package, waiting for iv_load
// SYNC  | S offered to the core
// SWAIT | waiting for E(S)
// READY | counter seeded, waiting for a block
// GEN   | stepped counter offered to the core
// GWAIT | waiting for the gamma
// OUT   | dout offered downstream
module gost28147_gamma
    import gost28147_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] iv,
    input  logic        iv_load,
    output logic        iv_ready,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
`ifdef GOST28147_GAMMA_PARTIAL_EN
    input  logic        din_last,
    input  logic [2:0]  din_nbytes,
`endif
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [63:0] core_pdata,
    output logic        core_pvalid,
    input  logic        core_pready,
    output logic        core_mode,
    input  logic [63:0] core_cdata,
    input  logic        core_cvalid,
    output logic        core_cready
);

    state_t      state_q, state_d;
    logic [63:0] din_q, din_d;
    logic [63:0] dout_q, dout_d;
    logic [63:0] pdata_q, pdata_d;
    logic        iv_ready_q, iv_ready_d;
    logic        din_ready_q, din_ready_d;
    logic        dout_valid_q, dout_valid_d;
    logic        pvalid_q, pvalid_d;
    logic        cready_q, cready_d;
    logic        ctr_load;
    logic        ctr_step;
    logic [63:0] ctr_next;
`ifdef GOST28147_GAMMA_PARTIAL_EN
    logic        last_q, last_d;
    logic [2:0]  nbytes_q, nbytes_d;
`endif

    gost28147_gamma_ctr u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .load_data (core_cdata),
        .step      (ctr_step),
        .ctr_next  (ctr_next)
    );

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        dout_d   = dout_q;
        pdata_d  = pdata_q;
        ctr_load = 1'b0;
        ctr_step = 1'b0;
`ifdef GOST28147_GAMMA_PARTIAL_EN
        last_d   = last_q;
        nbytes_d = nbytes_q;
`endif
        case (state_q)
            IDLE: begin
                if (iv_load) begin
                    pdata_d = iv;
                    state_d = SYNC;
                end
            end
            SYNC: if (core_pready) state_d = SWAIT;
            SWAIT: begin
                if (core_cvalid) begin
                    ctr_load = 1'b1;
                    state_d  = READY;
                end
            end
            READY: begin
                // a new synchro-package has priority over a pending block
                if (iv_load) begin
                    pdata_d = iv;
                    state_d = SYNC;
                end else if (din_valid) begin
                    din_d    = din;
                    ctr_step = 1'b1;
                    pdata_d  = ctr_next;
                    state_d  = GEN;
`ifdef GOST28147_GAMMA_PARTIAL_EN
                    last_d   = din_last;
                    nbytes_d = din_nbytes;
`endif
                end
            end
            GEN: if (core_pready) state_d = GWAIT;
            GWAIT: begin
                if (core_cvalid) begin
                    dout_d = din_q ^ core_cdata;
`ifdef GOST28147_GAMMA_PARTIAL_EN
                    for (int k = 0; k < 8; k++) begin
                        if (last_q && (nbytes_q != 3'd0) && (k[2:0] >= nbytes_q))
                            dout_d[8*k +: 8] = 8'h00;
                    end
`endif
                    state_d = OUT;
                end
            end
            OUT: begin
                if (dout_ready) begin
`ifdef GOST28147_GAMMA_PARTIAL_EN
                    state_d = last_q ? IDLE : READY;
`else
                    state_d = READY;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // handshake outputs are registered decodes of the next state
        iv_ready_d   = (state_d == IDLE) || (state_d == READY);
        din_ready_d  = (state_d == READY);
        pvalid_d     = (state_d == SYNC) || (state_d == GEN);
        cready_d     = (state_d == SWAIT) || (state_d == GWAIT);
        dout_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            din_q        <= 64'h0;
            dout_q       <= 64'h0;
            pdata_q      <= 64'h0;
            iv_ready_q   <= 1'b1;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            pvalid_q     <= 1'b0;
            cready_q     <= 1'b0;
`ifdef GOST28147_GAMMA_PARTIAL_EN
            last_q       <= 1'b0;
            nbytes_q     <= 3'd0;
`endif
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            dout_q       <= dout_d;
            pdata_q      <= pdata_d;
            iv_ready_q   <= iv_ready_d;
            din_ready_q  <= din_ready_d;
            dout_valid_q <= dout_valid_d;
            pvalid_q     <= pvalid_d;
            cready_q     <= cready_d;
`ifdef GOST28147_GAMMA_PARTIAL_EN
            last_q       <= last_d;
            nbytes_q     <= nbytes_d;
`endif
        end
    end

    assign iv_ready    = iv_ready_q;
    assign din_ready   = din_ready_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign core_pdata  = pdata_q;
    assign core_pvalid = pvalid_q;
    assign core_cready = cready_q;
    assign core_mode   = 1'b0;

endmodule

// File: tb/tb_gost28147_gamma.sv
// Bench for gost28147_gamma with a behavioural block-cipher stand-in on the
// core side (identity mode for exact counter vectors, scrambling mode for
// stream tests) and a gamma reference computed from the counter rules.
module tb_gost28147_gamma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] iv = 64'h0;
    logic        iv_load = 1'b0;
    logic        iv_ready;
    logic [63:0] din = 64'h0;
    logic        din_valid = 1'b0;
    logic        din_ready;
`ifdef GOST28147_GAMMA_PARTIAL_EN
    logic        din_last = 1'b0;
    logic [2:0]  din_nbytes = 3'd0;
`endif
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [63:0] core_pdata;
    logic        core_pvalid;
    logic        core_pready = 1'b0;
    logic        core_mode;
    logic [63:0] core_cdata = 64'h0;
    logic        core_cvalid = 1'b0;
    logic        core_cready;

    always #5 clk = ~clk;

    gost28147_gamma dut (
        .clk         (clk),
        .rst         (rst),
        .iv          (iv),
        .iv_load     (iv_load),
        .iv_ready    (iv_ready),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
`ifdef GOST28147_GAMMA_PARTIAL_EN
        .din_last    (din_last),
        .din_nbytes  (din_nbytes),
`endif
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .core_pdata  (core_pdata),
        .core_pvalid (core_pvalid),
        .core_pready (core_pready),
        .core_mode   (core_mode),
        .core_cdata  (core_cdata),
        .core_cvalid (core_cvalid),
        .core_cready (core_cready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // 64-bit stand-in for the 256-bit key BE5EC200..997C0672
    localparam logic [63:0] KEY = 64'hBE5EC200_997C0672;
    bit ident = 1'b0;

    function automatic logic [63:0] e_fn(input logic [63:0] x);
        logic [63:0] y;
        if (ident) return x;
        y = (x ^ KEY) * 64'h9E3779B97F4A7C15;
        return y ^ {y[20:0], y[63:21]};
    endfunction

    // ---------------- core stand-in ----------------
    bit          stall   = 1'b0;
    bit          flush   = 1'b0;
    int          lat_fix = -1;
    int          n_req   = 0;
    bit          pend    = 1'b0;
    logic [63:0] pend_data = 64'h0;
    int          lat_cnt = 0;
    logic        pv_s = 1'b0;
    logic        cr_s = 1'b0;
    logic [63:0] pd_s = 64'h0;

    always @(negedge clk) begin
        bit p_fire, c_fire;
        p_fire = pv_s && core_pready;
        c_fire = cr_s && core_cvalid;
        if (p_fire) begin
            pend      = 1'b1;
            pend_data = e_fn(pd_s);
            lat_cnt   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            n_req++;
        end
        if (c_fire) core_cvalid = 1'b0;
        if (flush) begin
            pend        = 1'b0;
            core_cvalid = 1'b0;
        end
        if (pend && !core_cvalid) begin
            if (lat_cnt == 0) begin
                core_cdata  = pend_data;
                core_cvalid = 1'b1;
                pend        = 1'b0;
            end else begin
                lat_cnt--;
            end
        end
        core_pready = !stall && !pend && !core_cvalid && ($urandom_range(0, 3) != 0);
        pv_s = core_pvalid;
        pd_s = core_pdata;
        cr_s = core_cready;
    end

    // ---------------- reference model ----------------
    logic [63:0] gam[$];

    function automatic logic [31:0] n4_add(input logic [31:0] a);
        logic [63:0] s;
        s = {32'h0, a} + 64'h0000_0000_0101_0104;
        if (s > 64'h0000_0000_FFFF_FFFF) s = s - 64'h0000_0000_FFFF_FFFF;
        return s[31:0];
    endfunction

    function automatic void build_gamma(input logic [63:0] s, input int n);
        logic [63:0] e;
        logic [31:0] n3, n4;
        gam.delete();
        e  = e_fn(s);
        n3 = e[31:0];
        n4 = e[63:32];
        for (int i = 0; i < n; i++) begin
            n3 = n3 + 32'h01010101;
            n4 = n4_add(n4);
            gam.push_back(e_fn({n4, n3}));
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic load_iv(input logic [63:0] v);
        int t = 0;
        while (!iv_ready && t < 300) begin @(negedge clk); t++; end
        if (!iv_ready) chk("iv_ready_timeout", 64'd0, 64'd1);
        iv = v;
        iv_load = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
        t = 0;
        while (!din_ready && t < 300) begin @(negedge clk); t++; end
        if (!din_ready) chk("sync_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_din(input logic [63:0] d);
        int t = 0;
        while (!din_ready && t < 300) begin @(negedge clk); t++; end
        if (!din_ready) chk("din_ready_timeout", 64'd0, 64'd1);
        din = d;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din = {$urandom, $urandom};
    endtask

    task automatic get_out(output logic [63:0] r, input int hold, input string nm);
        int t = 0;
        bit ok = 1'b1;
        logic [63:0] first;
        int req0;
        while (!dout_valid && t < 300) begin @(negedge clk); t++; end
        if (!dout_valid) chk({nm, "_timeout"}, 64'd0, 64'd1);
        first = dout;
        req0 = n_req;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (dout !== first || !dout_valid || din_ready || n_req != req0) ok = 1'b0;
        end
        if (hold > 0) chk({nm, "_hold"}, {63'd0, ok}, 64'd1);
        r = dout;
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] iv;
        logic [63:0] din;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r, ivr, pd0;
        logic [63:0] pt[4];
        logic [63:0] ct[4];
        bit ok, saw;

        // identity-core counter vectors: first gamma = S stepped once, second = twice
        tbl[0] = '{64'hFEFEFEFE_FFFFFFFF, 64'h0, 64'h00000003_01010100, 64'h01010107_02020201};
        tbl[1] = '{64'hFEFEFEFB_00000000, 64'h0, 64'hFFFFFFFF_01010101, 64'h01010104_02020202};
        tbl[2] = '{64'h00000000_00000000, 64'h01234567_89ABCDEF, 64'h00224463_88AACCEE, 64'h02020208_02020202};
        tbl[3] = '{64'hFFFFFFFF_FEFEFEFF, 64'h0, 64'h01010104_00000000, 64'h02020208_01010101};

        #2 rst = 1'b0;
        #1;
        chk("rst_handshakes", {59'd0, iv_ready, din_ready, dout_valid, core_pvalid, core_cready}, 64'h10);
        chk("rst_dout", dout, 64'h0);
        chk("rst_pdata", core_pdata, 64'h0);
        chk("core_mode", {63'd0, core_mode}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // block offered before any synchro-package is not taken
        din = 64'h1111_2222_3333_4444;
        din_valid = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (din_ready || core_pvalid || dout_valid) ok = 1'b0;
        end
        din_valid = 1'b0;
        chk("idle_din_ignored", {63'd0, ok}, 64'd1);
        chk("idle_no_core_req", n_req, 64'd0);

        // counter stepping vectors
        ident = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            load_iv(tbl[i].iv);
            send_din(tbl[i].din);
            get_out(r, 0, "tbl");
            chk($sformatf("tbl%0d_blk1", i), r, tbl[i].exp1);
            send_din(64'h0);
            get_out(r, 0, "tbl");
            chk($sformatf("tbl%0d_blk2", i), r, tbl[i].exp2);
        end

        // round trip streams with scrambling core
        ident = 1'b0;
        @(negedge clk);
        for (int tr = 0; tr < 3; tr++) begin
            ivr = (tr == 0) ? 64'h0 : {$urandom, $urandom};
            build_gamma(ivr, 4);
            load_iv(ivr);
            for (int i = 0; i < 4; i++) begin
                pt[i] = (tr == 0) ? 64'(i) : {$urandom, $urandom};
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_din(pt[i]);
                get_out(ct[i], 0, "enc");
                chk($sformatf("enc%0d_%0d", tr, i), ct[i], pt[i] ^ gam[i]);
            end
            load_iv(ivr);
            for (int i = 0; i < 4; i++) begin
                send_din(ct[i]);
                get_out(r, 0, "dec");
                chk($sformatf("dec%0d_%0d", tr, i), r, pt[i]);
            end
        end

        // backpressure in OUT
        ivr = {$urandom, $urandom};
        build_gamma(ivr, 1);
        load_iv(ivr);
        send_din(64'hA5A5_5A5A_0F0F_F0F0);
        get_out(r, 10, "bp");
        chk("bp_data", r, 64'hA5A5_5A5A_0F0F_F0F0 ^ gam[0]);

        // core stall in GEN with iv_load pulses that must be ignored
        ident = 1'b1;
        ivr = 64'h01234567_89ABCDEF;
        build_gamma(ivr, 2);
        load_iv(ivr);
        stall = 1'b1;
        @(negedge clk);
        din = 64'h0F1E2D3C_4B5A6978;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        pd0 = core_pdata;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!core_pvalid || core_pdata !== pd0) ok = 1'b0;
            iv = {$urandom, $urandom};
            iv_load = i[0];
            @(negedge clk);
        end
        iv_load = 1'b0;
        chk("stall_stable", {63'd0, ok}, 64'd1);
        chk("stall_pdata", pd0, gam[0]);
        stall = 1'b0;
        get_out(r, 0, "stall");
        chk("stall_dout", r, 64'h0F1E2D3C_4B5A6978 ^ gam[0]);
        send_din(64'h0);
        get_out(r, 0, "stall");
        chk("stall_next_dout", r, gam[1]);

        // iv_load and din_valid together in READY
        ivr = 64'h13579BDF_02468ACE;
        build_gamma(ivr, 1);
        iv = ivr;
        iv_load = 1'b1;
        din = 64'hDEAD_BEEF_DEAD_BEEF;
        din_valid = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
        din_valid = 1'b0;
        chk("ivwins_pvalid", {63'd0, core_pvalid}, 64'd1);
        chk("ivwins_pdata", core_pdata, ivr);
        load_iv(ivr);
        send_din(64'h5555_AAAA_5555_AAAA);
        get_out(r, 0, "ivwins");
        chk("ivwins_dout", r, 64'h5555_AAAA_5555_AAAA ^ gam[0]);

        // asynchronous reset while waiting for the gamma
        ident = 1'b0;
        lat_fix = 8;
        @(negedge clk);
        ivr = {$urandom, $urandom};
        load_iv(ivr);
        send_din(64'h7777_8888_9999_0000);
        begin
            int t = 0;
            while (!core_cready && t < 50) begin @(negedge clk); t++; end
        end
        chk("gwait_reached", {63'd0, core_cready}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_handshakes", {59'd0, iv_ready, din_ready, dout_valid, core_pvalid, core_cready}, 64'h10);
        chk("rstmid_dout", dout, 64'h0);
        chk("rstmid_pdata", core_pdata, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        saw = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (core_cvalid) saw = 1'b1;
            if (dout_valid || core_cready || din_ready || !iv_ready) ok = 1'b0;
        end
        chk("rstmid_cvalid_dropped", {62'd0, saw, ok}, 64'd3);
        flush = 1'b1;
        lat_fix = -1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        ivr = {$urandom, $urandom};
        build_gamma(ivr, 2);
        load_iv(ivr);
        for (int i = 0; i < 2; i++) begin
            pt[i] = {$urandom, $urandom};
            send_din(pt[i]);
            get_out(r, 0, "fresh");
            chk($sformatf("fresh_%0d", i), r, pt[i] ^ gam[i]);
        end

`ifdef GOST28147_GAMMA_PARTIAL_EN
        // short last block, then no block accepted until a new synchro-package
        ivr = {$urandom, $urandom};
        build_gamma(ivr, 1);
        load_iv(ivr);
        din_last = 1'b1;
        din_nbytes = 3'd3;
        send_din(64'hFFFF_FFFF_FFFF_FFFF);
        din_last = 1'b0;
        din_nbytes = 3'd0;
        get_out(r, 0, "partial");
        chk("partial_dout", r, (64'hFFFF_FFFF_FFFF_FFFF ^ gam[0]) & 64'h0000_0000_00FF_FFFF);
        chk("partial_idle", {62'd0, iv_ready, din_ready}, 64'd2);
        begin
            int req0;
            req0 = n_req;
            din = 64'h1234;
            din_valid = 1'b1;
            ok = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (din_ready || core_pvalid || dout_valid) ok = 1'b0;
            end
            din_valid = 1'b0;
            chk("partial_din_blocked", {63'd0, ok}, 64'd1);
            chk("partial_no_req", n_req, req0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
